// File: rtl/ula_dispatch_if.sv
// Bundles the instruction, ALU and result/debug signals of ula_dispatch.
// The slave modport is the dispatcher; master is whoever drives instructions and plays the ALU.
interface ula_dispatch_if;
    logic        instr_valid;
    logic [13:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [7:0]  alu_result;
    logic        alu_sinal;
    logic        result_valid;
    logic [7:0]  result_data;
    logic        flag_neg;
    logic        err;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    modport slave (
        input  instr_valid, instr, alu_result, alu_sinal, dbg_sel,
        output instr_ready, alu_op, alu_a, alu_b, result_valid, result_data,
               flag_neg, err, dbg_data
    );

    modport master (
        output instr_valid, instr, alu_result, alu_sinal, dbg_sel,
        input  instr_ready, alu_op, alu_a, alu_b, result_valid, result_data,
               flag_neg, err, dbg_data
    );
endinterface

// File: rtl/ula_dispatch.sv
// Single-issue dispatcher: decodes 14-bit instructions, drives an external registered ALU, writes back into a 4x8 register file.
// Define ULA_DISPATCH_DIV0_EN to reject div (0111) whose divisor register reads zero instead of issuing it.
module ula_dispatch (
    input  logic           clk,
    input  logic           rst,
    ula_dispatch_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        CAPT = 2'b10
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1000;

    state_t      state_q, state_d;
    logic [7:0]  rf [0:3];
    logic [1:0]  rd_q;

    logic [3:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [3:0]  imm;
    logic        is_alu, is_ldi, is_illegal, div0_block;
    logic        issue, ldi_wr, reject;

    assign op  = bus.instr[13:10];
    assign rd  = bus.instr[9:8];
    assign rs1 = bus.instr[7:6];
    assign rs2 = bus.instr[5:4];
    assign imm = bus.instr[3:0];

    assign is_alu     = (op != OP_NOP) && !op[3];
    assign is_ldi     = (op == OP_LDI);
    assign is_illegal = op[3] && (op != OP_LDI);

`ifdef ULA_DISPATCH_DIV0_EN
    assign div0_block = (op == OP_DIV) && (rf[rs2][3:0] == 4'h0);
`else
    assign div0_block = 1'b0;
`endif

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.dbg_data    = rf[bus.dbg_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        issue   = 1'b0;
        ldi_wr  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    if (is_alu && !div0_block) begin
                        issue   = 1'b1;
                        state_d = EXEC;
                    end else if (is_ldi) begin
                        ldi_wr = 1'b1;
                    end else if (is_illegal || div0_block) begin
                        reject = 1'b1;
                    end
                end
            end
            EXEC:    state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are read from rf in the accept cycle, so rs == rd sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is cleared on reset because software relies on every register starting at zero.
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
            rd_q             <= 2'd0;
            bus.alu_op       <= 4'h0;
            bus.alu_a        <= 4'h0;
            bus.alu_b        <= 4'h0;
            bus.result_valid <= 1'b0;
            bus.result_data  <= 8'h00;
            bus.flag_neg     <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            bus.err          <= 1'b0;
            if (issue) begin
                bus.alu_op <= op;
                bus.alu_a  <= rf[rs1][3:0];
                bus.alu_b  <= rf[rs2][3:0];
                rd_q       <= rd;
            end
            if (ldi_wr) begin
                rf[rd]           <= {4'b0000, imm};
                bus.result_data  <= {4'b0000, imm};
                bus.result_valid <= 1'b1;
            end
            if (reject) bus.err <= 1'b1;
            if (state_q == CAPT) begin
                rf[rd_q]         <= bus.alu_result;
                bus.result_data  <= bus.alu_result;
                bus.flag_neg     <= bus.alu_sinal;
                bus.result_valid <= 1'b1;
                bus.alu_op       <= OP_NOP;
            end
        end
    end
endmodule

// File: tb/tb_ula_dispatch.sv
// Directed test of ula_dispatch; the bench also plays the registered ALU.
`timescale 1ns/1ps
module tb_ula_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ula_dispatch_if bus ();

    ula_dispatch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Registered ALU: result appears one edge after alu_op/alu_a/alu_b.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_result <= 8'h00;
            bus.alu_sinal  <= 1'b0;
        end else begin
            case (bus.alu_op)
                4'h1:    bus.alu_result <= {4'h0, bus.alu_a} + {4'h0, bus.alu_b};
                4'h2:    bus.alu_result <= {4'h0, bus.alu_a} - {4'h0, bus.alu_b};
                4'h3:    bus.alu_result <= {4'h0, bus.alu_a} * {4'h0, bus.alu_b};
                4'h4:    bus.alu_result <= {4'h0, bus.alu_a & bus.alu_b};
                4'h5:    bus.alu_result <= {4'h0, bus.alu_a | bus.alu_b};
                4'h6:    bus.alu_result <= {4'h0, bus.alu_a ^ bus.alu_b};
                4'h7:    bus.alu_result <= (bus.alu_b == 4'h0) ? 8'hFF : {4'h0, bus.alu_a / bus.alu_b};
                default: bus.alu_result <= 8'h00;
            endcase
            bus.alu_sinal <= (bus.alu_op == 4'h2) && (bus.alu_a < bus.alu_b);
        end
    end

    function automatic logic [13:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic [3:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for exactly one rising edge; returns 1ns after that edge.
    task automatic send(input logic [13:0] i);
        @(negedge clk);
        bus.instr       = i;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic read_rf(input logic [1:0] sel, output logic [7:0] v);
        bus.dbg_sel = sel;
        #1;
        v = bus.dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        #2;
        total++; if (bus.alu_op !== 4'h0)        begin bad++; $display("FAIL reset_alu_op got=%h exp=0", bus.alu_op); end
        total++; if (bus.result_valid !== 1'b0)  begin bad++; $display("FAIL reset_result_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.result_data !== 8'h00)  begin bad++; $display("FAIL reset_result_data got=%h exp=00", bus.result_data); end
        total++; if (bus.err !== 1'b0)           begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        total++; if (bus.flag_neg !== 1'b0)      begin bad++; $display("FAIL reset_flag_neg got=%b exp=0", bus.flag_neg); end
        for (int r = 0; r < 4; r++) begin
            read_rf(r[1:0], v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_rf%0d got=%h exp=00", r, v); end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    endtask

    task automatic test_ldi_add();
        logic [7:0] v;
        send(enc(4'h8, 2'd1, 2'd0, 2'd0, 4'd5));
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL ldi_valid got=%b exp=1", bus.result_valid); end
        total++; if (bus.result_data !== 8'h05) begin bad++; $display("FAIL ldi_data got=%h exp=05", bus.result_data); end
        total++; if (bus.instr_ready !== 1'b1)  begin bad++; $display("FAIL ldi_ready got=%b exp=1", bus.instr_ready); end
        send(enc(4'h8, 2'd2, 2'd0, 2'd0, 4'd3));
        send(enc(4'h1, 2'd0, 2'd1, 2'd2, 4'd0));
        total++; if (bus.alu_op !== 4'h1)       begin bad++; $display("FAIL add_alu_op got=%h exp=1", bus.alu_op); end
        total++; if (bus.alu_a !== 4'h5)        begin bad++; $display("FAIL add_alu_a got=%h exp=5", bus.alu_a); end
        total++; if (bus.alu_b !== 4'h3)        begin bad++; $display("FAIL add_alu_b got=%h exp=3", bus.alu_b); end
        total++; if (bus.instr_ready !== 1'b0)  begin bad++; $display("FAIL add_ready_exec got=%b exp=0", bus.instr_ready); end
        step();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.instr_ready !== 1'b0)  begin bad++; $display("FAIL add_ready_capt got=%b exp=0", bus.instr_ready); end
        step();
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", bus.result_valid); end
        total++; if (bus.result_data !== 8'h08) begin bad++; $display("FAIL add_data got=%h exp=08", bus.result_data); end
        total++; if (bus.alu_op !== 4'h0)       begin bad++; $display("FAIL add_op_clear got=%h exp=0", bus.alu_op); end
        total++; if (bus.instr_ready !== 1'b1)  begin bad++; $display("FAIL add_ready_idle got=%b exp=1", bus.instr_ready); end
        read_rf(2'd0, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL add_rf0 got=%h exp=08", v); end
        step();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL add_pulse_len got=%b exp=0", bus.result_valid); end
    endtask

    task automatic test_mul();
        logic [7:0] v;
        send(enc(4'h8, 2'd1, 2'd0, 2'd0, 4'd15));
        send(enc(4'h8, 2'd2, 2'd0, 2'd0, 4'd15));
        send(enc(4'h3, 2'd3, 2'd1, 2'd2, 4'd0));
        step();
        step();
        total++; if (bus.result_data !== 8'hE1) begin bad++; $display("FAIL mul_data got=%h exp=e1", bus.result_data); end
        read_rf(2'd3, v);
        total++; if (v !== 8'hE1) begin bad++; $display("FAIL mul_rf3 got=%h exp=e1", v); end
    endtask

    task automatic test_sub_neg();
        logic [7:0] v;
        send(enc(4'h8, 2'd1, 2'd0, 2'd0, 4'd5));
        send(enc(4'h8, 2'd2, 2'd0, 2'd0, 4'd3));
        send(enc(4'h2, 2'd0, 2'd2, 2'd1, 4'd0));
        step();
        step();
        total++; if (bus.flag_neg !== 1'b1)     begin bad++; $display("FAIL sub_flag_neg got=%b exp=1", bus.flag_neg); end
        total++; if (bus.result_data !== 8'hFE) begin bad++; $display("FAIL sub_data got=%h exp=fe", bus.result_data); end
        read_rf(2'd0, v);
        total++; if (v !== 8'hFE) begin bad++; $display("FAIL sub_rf0 got=%h exp=fe", v); end
        send(enc(4'h8, 2'd0, 2'd0, 2'd0, 4'd7));
        total++; if (bus.flag_neg !== 1'b1)     begin bad++; $display("FAIL ldi_keeps_flag got=%b exp=1", bus.flag_neg); end
        total++; if (bus.result_data !== 8'h07) begin bad++; $display("FAIL ldi_r0_data got=%h exp=07", bus.result_data); end
    endtask

    task automatic test_same_reg();
        logic [7:0] v;
        send(enc(4'h1, 2'd1, 2'd1, 2'd1, 4'd0));
        step();
        step();
        read_rf(2'd1, v);
        total++; if (v !== 8'h0A)           begin bad++; $display("FAIL samereg_rf1 got=%h exp=0a", v); end
        total++; if (bus.flag_neg !== 1'b0) begin bad++; $display("FAIL samereg_flag got=%b exp=0", bus.flag_neg); end
    endtask

    task automatic test_illegal();
        logic [7:0] v;
        send(enc(4'hA, 2'd1, 2'd0, 2'd0, 4'd9));
        total++; if (bus.err !== 1'b1)          begin bad++; $display("FAIL illegal_err got=%b exp=1", bus.err); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.instr_ready !== 1'b1)  begin bad++; $display("FAIL illegal_ready got=%b exp=1", bus.instr_ready); end
        read_rf(2'd1, v);
        total++; if (v !== 8'h0A) begin bad++; $display("FAIL illegal_rf1 got=%h exp=0a", v); end
        step();
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL illegal_err_len got=%b exp=0", bus.err); end
    endtask

    task automatic test_nop();
        logic [7:0] v;
        send(enc(4'h0, 2'd2, 2'd1, 2'd1, 4'd9));
        total++; if (bus.err !== 1'b0 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL nop_pulses got=%b%b exp=00", bus.err, bus.result_valid); end
        total++; if (bus.alu_op !== 4'h0 || bus.instr_ready !== 1'b1) begin bad++; $display("FAIL nop_state got=%h/%b exp=0/1", bus.alu_op, bus.instr_ready); end
        read_rf(2'd2, v);
        total++; if (v !== 8'h03) begin bad++; $display("FAIL nop_rf2 got=%h exp=03", v); end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] v;
        send(enc(4'h1, 2'd0, 2'd1, 2'd2, 4'd0));
        bus.instr       = enc(4'h8, 2'd3, 2'd0, 2'd0, 4'd9);
        bus.instr_valid = 1'b1;
        step();
        step();
        bus.instr_valid = 1'b0;
        total++; if (bus.result_data !== 8'h0D) begin bad++; $display("FAIL busy_add_data got=%h exp=0d", bus.result_data); end
        read_rf(2'd3, v);
        total++; if (v !== 8'hE1) begin bad++; $display("FAIL busy_rf3 got=%h exp=e1", v); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.instr       = enc(4'h8, 2'd2, 2'd0, 2'd0, 4'd4);
        bus.instr_valid = 1'b1;
        step();
        total++; if (bus.result_data !== 8'h04) begin bad++; $display("FAIL b2b_first got=%h exp=04", bus.result_data); end
        bus.instr = enc(4'h8, 2'd3, 2'd0, 2'd0, 4'd6);
        step();
        bus.instr_valid = 1'b0;
        total++; if (bus.result_data !== 8'h06 || bus.result_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=06/1", bus.result_data, bus.result_valid); end
        step();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", bus.result_valid); end
    endtask

    task automatic test_div0();
        logic [7:0] v;
        send(enc(4'h8, 2'd0, 2'd0, 2'd0, 4'd0));
        send(enc(4'h7, 2'd1, 2'd2, 2'd0, 4'd0));
`ifdef ULA_DISPATCH_DIV0_EN
        total++; if (bus.err !== 1'b1)          begin bad++; $display("FAIL div0_err got=%b exp=1", bus.err); end
        total++; if (bus.alu_op !== 4'h0)       begin bad++; $display("FAIL div0_op got=%h exp=0", bus.alu_op); end
        total++; if (bus.instr_ready !== 1'b1)  begin bad++; $display("FAIL div0_ready got=%b exp=1", bus.instr_ready); end
        step();
        step();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL div0_valid got=%b exp=0", bus.result_valid); end
        read_rf(2'd1, v);
        total++; if (v !== 8'h0A) begin bad++; $display("FAIL div0_rf1 got=%h exp=0a", v); end
`else
        total++; if (bus.alu_op !== 4'h7 || bus.alu_b !== 4'h0) begin bad++; $display("FAIL div0_issue got=%h/%h exp=7/0", bus.alu_op, bus.alu_b); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL div0_err got=%b exp=0", bus.err); end
        step();
        step();
        total++; if (bus.result_valid !== 1'b1 || bus.result_data !== 8'hFF) begin bad++; $display("FAIL div0_wb got=%b/%h exp=1/ff", bus.result_valid, bus.result_data); end
        read_rf(2'd1, v);
        total++; if (v !== 8'hFF) begin bad++; $display("FAIL div0_rf1 got=%h exp=ff", v); end
`endif
    endtask

    task automatic test_reset_capt();
        logic [7:0] v;
        send(enc(4'h8, 2'd1, 2'd0, 2'd0, 4'd2));
        send(enc(4'h1, 2'd3, 2'd1, 2'd1, 4'd0));
        step();
        rst = 1'b1;
        #1;
        total++; if (bus.alu_op !== 4'h0 || bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0) begin bad++; $display("FAIL rstcapt_alu got=%h%h%h exp=000", bus.alu_op, bus.alu_a, bus.alu_b); end
        total++; if (bus.result_valid !== 1'b0 || bus.result_data !== 8'h00) begin bad++; $display("FAIL rstcapt_result got=%b/%h exp=0/00", bus.result_valid, bus.result_data); end
        total++; if (bus.flag_neg !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL rstcapt_flags got=%b%b exp=00", bus.flag_neg, bus.err); end
        read_rf(2'd1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL rstcapt_rf1 got=%h exp=00", v); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL rstcapt_ready got=%b exp=1", bus.instr_ready); end
        step();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL rstcapt_no_wb got=%b exp=0", bus.result_valid); end
        read_rf(2'd3, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL rstcapt_rf3 got=%h exp=00", v); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 14'h0;
        bus.dbg_sel     = 2'd0;
        test_reset();
        test_ldi_add();
        test_mul();
        test_sub_neg();
        test_same_reg();
        test_illegal();
        test_nop();
        test_ignore_busy();
        test_back_to_back();
        test_div0();
        test_reset_capt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ula_dispatch.md
ULA_DISPATCH -- requirements
Module: ula_dispatch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports as below.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  14  {op[13:10], rd[9:8], rs1[7:6], rs2[5:4], imm[3:0]}.
REQ-006 instr_ready  output  1  high only in IDLE; transfer when instr_valid & instr_ready at a rising edge.
REQ-007 alu_op  output  4  registered opcode to ALU.
REQ-008 alu_a  output  4  registered operand A = rf[rs1][3:0].
REQ-009 alu_b  output  4  registered operand B = rf[rs2][3:0].
REQ-010 alu_result  input  8  ALU registered result (valid one edge after alu_op/alu_a/alu_b change).
REQ-011 alu_sinal  input  1  ALU sign flag, sampled with alu_result.
REQ-012 result_valid  output  1  one-cycle pulse: write-back done.
REQ-013 result_data  output  8  value written; held until next write-back.
REQ-014 flag_neg  output  1  alu_sinal captured at last ALU write-back.
REQ-015 err  output  1  one-cycle pulse: instruction rejected.
REQ-016 dbg_sel  input  2  register-file read select.
REQ-017 dbg_data  output  8  combinational rf[dbg_sel].

Function
REQ-018 Register file SHALL be 4 x 8 bits; only write path is write-back below.
REQ-019 FSM states SHALL be IDLE, EXEC, CAPT; all other encodings return to IDLE.
REQ-020 Opcode map SHALL be: 0000 NOP; 0001-0111 ALU ops (add, sub, mul, and, or, xor, div); 1000 LDI; 1001-1111 illegal.
REQ-021 IDLE, accepted ALU op at edge E0: alu_op/alu_a/alu_b SHALL load at E0, rd latched, state -> EXEC.
REQ-022 EXEC: no register action; state -> CAPT at E1 (ALU registers its result at E1).
REQ-023 CAPT: at E2 rf[rd] <= alu_result, result_data <= alu_result, flag_neg <= alu_sinal, result_valid high for the following cycle, alu_op <= 0000, state -> IDLE.
REQ-024 ALU-op latency SHALL be exactly 3 cycles accept-to-result_valid; throughput one op per 3 cycles.
REQ-025 LDI accepted at E0 SHALL write rf[rd] <= {4'b0000, imm} and result_data likewise, pulse result_valid next cycle, stay IDLE; flag_neg unchanged.
REQ-026 NOP SHALL be accepted with no state change and no pulses.
REQ-027 Illegal opcode SHALL be accepted, pulse err next cycle, no rf write, stay IDLE.
REQ-028 Operands SHALL be read from rf at acceptance; rs1 or rs2 equal to rd is legal (old value used).
REQ-029 alu_op SHALL be 0000 whenever state is IDLE, except the cycle following acceptance.
REQ-030 instr, instr_valid SHALL be ignored outside IDLE; no queueing.

Reset
REQ-031 rst SHALL immediately force state IDLE, rf all 0, alu_op/alu_a/alu_b 0, result_valid 0, result_data 0, flag_neg 0, err 0.
REQ-032 rst in EXEC or CAPT SHALL abort the op with no write-back; instr_ready high first cycle after rst deasserts.

Configuration
REQ-033 With ULA_DISPATCH_DIV0_EN defined, an accepted div (0111) with rf[rs2][3:0] == 0 SHALL not be issued: err pulses next cycle, no rf write, stay IDLE.
REQ-034 Without ULA_DISPATCH_DIV0_EN, div by zero SHALL be issued normally and whatever alu_result returns SHALL be written back.

Verification
REQ-035 LDI r1,5; LDI r2,3; add r0,r1,r2 -> alu_a=5, alu_b=3, alu_op=0001 next cycle; result_valid 3 cycles after accept; rf[0]=8.
REQ-036 LDI r1,15; LDI r2,15; mul r3,r1,r2 -> rf[3]=225 (8'hE1), dbg_sel=3 reads 8'hE1.
REQ-037 sub r0,r2,r1 with rf[2]=3, rf[1]=5, ALU sinal=1 -> flag_neg=1, result_data equals alu_result.
REQ-038 instr op=1010 -> err pulse 1 cycle, rf unchanged, instr_ready stays 1.
REQ-039 rst asserted in CAPT -> all outputs 0 immediately, no result_valid, rf all 0.
REQ-040 div with rf[rs2]=0: with ULA_DISPATCH_DIV0_EN -> err, alu_op stays 0000; without -> issued, write-back after 3 cycles.
